// File: rtl/rtc_bus_write_seq.sv
// Single write transaction to the RTC multiplexed address/data bus: an address phase
// followed by a data phase, each with programmable setup, strobe and hold lengths.
module rtc_bus_write_seq #(
  parameter int unsigned SU_CYC = 2,
  parameter int unsigned PW_CYC = 4,
  parameter int unsigned HD_CYC = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic [7:0] addr,
  input  logic [7:0] data_in,
  output logic       busy,
  output logic       done,
  output logic       cs_n,
  output logic       rd_n,
  output logic       wr_n,
  output logic       a_d,
  output logic [7:0] ad_out,
  output logic       ad_oe
);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    A_SU = 3'd1,
    A_PW = 3'd2,
    A_HD = 3'd3,
    D_SU = 3'd4,
    D_PW = 3'd5,
    D_HD = 3'd6,
    DONE = 3'd7
  } state_t;

  state_t     state_q, state_d;
  logic [7:0] cnt_q, cnt_d;
  logic [7:0] addr_q, addr_d;
  logic [7:0] data_q, data_d;

  logic       busy_q, busy_d;
  logic       done_q, done_d;
  logic       cs_n_q, cs_n_d;
  logic       wr_n_q, wr_n_d;
  logic       a_d_q, a_d_d;
  logic [7:0] ad_out_q, ad_out_d;
  logic       ad_oe_q, ad_oe_d;

  // Counter preload for a state: its length minus one, so zero marks the last cycle.
  function automatic logic [7:0] phase_len_m1(input state_t s);
    logic [7:0] len;
    len = 8'd0;
    case (s)
      A_SU, D_SU: len = 8'(SU_CYC - 1);
      A_PW, D_PW: len = 8'(PW_CYC - 1);
      A_HD, D_HD: len = 8'(HD_CYC - 1);
      default:    len = 8'd0;
    endcase
    return len;
  endfunction

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      cnt_q    <= 8'd0;
      addr_q   <= 8'h00;
      data_q   <= 8'h00;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      cs_n_q   <= 1'b1;
      wr_n_q   <= 1'b1;
      a_d_q    <= 1'b0;
      ad_out_q <= 8'h00;
      ad_oe_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      addr_q   <= addr_d;
      data_q   <= data_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      cs_n_q   <= cs_n_d;
      wr_n_q   <= wr_n_d;
      a_d_q    <= a_d_d;
      ad_out_q <= ad_out_d;
      ad_oe_q  <= ad_oe_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = A_SU;
      A_SU:    if (cnt_q == 8'd0) state_d = A_PW;
      A_PW:    if (cnt_q == 8'd0) state_d = A_HD;
      A_HD:    if (cnt_q == 8'd0) state_d = D_SU;
      D_SU:    if (cnt_q == 8'd0) state_d = D_PW;
      D_PW:    if (cnt_q == 8'd0) state_d = D_HD;
      D_HD:    if (cnt_q == 8'd0) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    cnt_d  = cnt_q;
    addr_d = addr_q;
    data_d = data_q;
    if (state_d != state_q) begin
      cnt_d = phase_len_m1(state_d);
    end else if (cnt_q != 8'd0) begin
      cnt_d = cnt_q - 8'd1;
    end
    if ((state_q == IDLE) && start) begin
      addr_d = addr;
      data_d = data_in;
    end
  end

  // Outputs are decoded from the next state so they change on the same edge as the state.
  always_comb begin
    busy_d   = 1'b0;
    done_d   = 1'b0;
    cs_n_d   = 1'b1;
    wr_n_d   = 1'b1;
    a_d_d    = 1'b0;
    ad_out_d = 8'h00;
    ad_oe_d  = 1'b0;
    case (state_d)
      A_SU, A_PW, A_HD: begin
        busy_d   = 1'b1;
        cs_n_d   = 1'b0;
        ad_oe_d  = 1'b1;
        ad_out_d = addr_d;
        wr_n_d   = (state_d != A_PW);
      end
      D_SU, D_PW, D_HD: begin
        busy_d   = 1'b1;
        cs_n_d   = 1'b0;
        ad_oe_d  = 1'b1;
        a_d_d    = 1'b1;
        ad_out_d = data_d;
        wr_n_d   = (state_d != D_PW);
      end
      DONE:    done_d = 1'b1;
      default: ;
    endcase
  end

  assign busy   = busy_q;
  assign done   = done_q;
  assign cs_n   = cs_n_q;
  assign rd_n   = 1'b1;
  assign wr_n   = wr_n_q;
  assign a_d    = a_d_q;
  assign ad_out = ad_out_q;
  assign ad_oe  = ad_oe_q;

endmodule

// File: tb/tb_rtc_bus_write_seq.sv
// Directed vector bench for rtc_bus_write_seq: default timing instance plus a 1/1/1 timing instance.
module tb_rtc_bus_write_seq;

  logic       clk = 1'b0;
  logic       reset;
  logic       start0, start1;
  logic [7:0] addr, data_in;

  logic       busy0, done0, cs_n0, rd_n0, wr_n0, a_d0, ad_oe0;
  logic [7:0] ad_out0;
  logic       busy1, done1, cs_n1, rd_n1, wr_n1, a_d1, ad_oe1;
  logic [7:0] ad_out1;

  int nvec = 0;
  int nmis = 0;
  logic mon_en = 1'b0;

  always #5 clk = ~clk;

  rtc_bus_write_seq dut0 (
    .clk(clk), .reset(reset), .start(start0), .addr(addr), .data_in(data_in),
    .busy(busy0), .done(done0), .cs_n(cs_n0), .rd_n(rd_n0), .wr_n(wr_n0),
    .a_d(a_d0), .ad_out(ad_out0), .ad_oe(ad_oe0)
  );

  rtc_bus_write_seq #(.SU_CYC(1), .PW_CYC(1), .HD_CYC(1)) dut1 (
    .clk(clk), .reset(reset), .start(start1), .addr(addr), .data_in(data_in),
    .busy(busy1), .done(done1), .cs_n(cs_n1), .rd_n(rd_n1), .wr_n(wr_n1),
    .a_d(a_d1), .ad_out(ad_out1), .ad_oe(ad_oe1)
  );

  // Packed view: {busy, done, cs_n, rd_n, wr_n, a_d, ad_oe, ad_out}
  wire [14:0] out0 = {busy0, done0, cs_n0, rd_n0, wr_n0, a_d0, ad_oe0, ad_out0};
  wire [14:0] out1 = {busy1, done1, cs_n1, rd_n1, wr_n1, a_d1, ad_oe1, ad_out1};
  localparam logic [14:0] IDLE_OUT = {1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 8'h00};

  typedef struct {
    logic       st;
    logic       rs;
    logic [7:0] a;
    logic [7:0] d;
    logic [14:0] exp;
  } vec_t;
  vec_t tbl[$];

  // Expected outputs in cycle c of a transaction (cycle 1 = first cycle after start is accepted).
  function automatic logic [14:0] exp_out(input int c, input int su, input int pw, input int hd,
                                          input logic [7:0] a, input logic [7:0] d);
    int   t;
    int   p;
    logic ph;
    logic wl;
    t = su + pw + hd;
    if (c >= 1 && c <= 2 * t) begin
      p  = (c - 1) % t;
      ph = (c > t);
      wl = (p >= su && p < su + pw);
      return {1'b1, 1'b0, 1'b0, 1'b1, ~wl, ph, 1'b1, (ph ? d : a)};
    end else if (c == 2 * t + 1) begin
      return {1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 8'h00};
    end
    return IDLE_OUT;
  endfunction

  task automatic add(input logic st, input logic rs, input logic [7:0] a, input logic [7:0] d,
                     input logic [14:0] exp);
    vec_t v;
    v.st = st; v.rs = rs; v.a = a; v.d = d; v.exp = exp;
    tbl.push_back(v);
  endtask

  task automatic check(input string nm, input logic [14:0] got, input logic [14:0] exp);
    nvec++;
    if (got !== exp) begin
      nmis++;
      $display("FAIL %s: got %h required %h", nm, got, exp);
    end
  endtask

  task automatic check_int(input string nm, input int got, input int exp);
    nvec++;
    if (got != exp) begin
      nmis++;
      $display("FAIL %s: got %0d required %0d", nm, got, exp);
    end
  endtask

  task automatic run_table(input int sel, input string nm);
    for (int i = 0; i < tbl.size(); i++) begin
      reset   = tbl[i].rs;
      addr    = tbl[i].a;
      data_in = tbl[i].d;
      if (sel == 0) start0 = tbl[i].st;
      else          start1 = tbl[i].st;
      @(posedge clk);
      #1;
      check($sformatf("%s[%0d]", nm, i), (sel == 0) ? out0 : out1, tbl[i].exp);
    end
    start0 = 1'b0;
    start1 = 1'b0;
    reset  = 1'b0;
    tbl.delete();
  endtask

  // Bus protocol monitor for both instances.
  logic       pw0, pcs0, pad0;
  logic [7:0] pbus0;
  logic       pw1, pcs1, pad1;
  logic [7:0] pbus1;
  always @(negedge clk) begin
    if (mon_en) begin
      if (wr_n0 === 1'b0 && !(cs_n0 === 1'b0 && ad_oe0 === 1'b1)) begin
        nmis++; $display("FAIL mon0_wr_without_cs: cs_n=%b ad_oe=%b required 0/1", cs_n0, ad_oe0);
      end
      if (rd_n0 !== 1'b1) begin
        nmis++; $display("FAIL mon0_rd_n: got %b required 1", rd_n0);
      end
      if (pw0 && !wr_n0 && (pcs0 !== cs_n0 || pad0 !== a_d0 || pbus0 !== ad_out0)) begin
        nmis++; $display("FAIL mon0_wr_fall_setup: bus changed with wr_n fall, required stable");
      end
      if (wr_n1 === 1'b0 && !(cs_n1 === 1'b0 && ad_oe1 === 1'b1)) begin
        nmis++; $display("FAIL mon1_wr_without_cs: cs_n=%b ad_oe=%b required 0/1", cs_n1, ad_oe1);
      end
      if (rd_n1 !== 1'b1) begin
        nmis++; $display("FAIL mon1_rd_n: got %b required 1", rd_n1);
      end
      if (pw1 && !wr_n1 && (pcs1 !== cs_n1 || pad1 !== a_d1 || pbus1 !== ad_out1)) begin
        nmis++; $display("FAIL mon1_wr_fall_setup: bus changed with wr_n fall, required stable");
      end
    end
    pw0 = wr_n0; pcs0 = cs_n0; pad0 = a_d0; pbus0 = ad_out0;
    pw1 = wr_n1; pcs1 = cs_n1; pad1 = a_d1; pbus1 = ad_out1;
  end

  initial begin
    int busyc;
    int donec;
    int wrmask;

    reset = 1'b1; start0 = 1'b1; start1 = 1'b1; addr = 8'hEE; data_in = 8'hDD;
    repeat (3) @(posedge clk);
    #1;
    check("reset_dut0", out0, IDLE_OUT);
    check("reset_dut1", out1, IDLE_OUT);
    reset = 1'b0; start0 = 1'b0; start1 = 1'b0;
    @(posedge clk);
    #1;
    mon_en = 1'b1;

    // Default single transaction.
    add(1'b1, 1'b0, 8'h02, 8'h10, exp_out(1, 2, 4, 2, 8'h02, 8'h10));
    for (int c = 2; c <= 19; c++) add(1'b0, 1'b0, 8'h02, 8'h10, exp_out(c, 2, 4, 2, 8'h02, 8'h10));
    run_table(0, "single");

    // Starts during busy/DONE plus addr/data_in churn are ignored.
    for (int r = 0; r <= 18; r++) begin
      logic st;
      logic [7:0] a, d;
      st = (r == 0 || r == 5 || r == 11 || r == 17);
      a  = (r == 0) ? 8'h02 : ((r % 2 == 1) ? 8'hFF : 8'h77);
      d  = (r == 0) ? 8'h10 : ((r % 2 == 1) ? 8'hA5 : 8'h5A);
      add(st, 1'b0, a, d, exp_out(r + 1, 2, 4, 2, 8'h02, 8'h10));
    end
    run_table(0, "ignore_start");

    // Back-to-back with start held: initial word then final word.
    for (int r = 0; r <= 35; r++) begin
      int c, loc;
      c   = r + 1;
      loc = ((c - 1) % 18) + 1;
      add((r <= 34), 1'b0, 8'h02, (r == 0) ? 8'h08 : 8'h28,
          exp_out(loc, 2, 4, 2, 8'h02, (c <= 18) ? 8'h08 : 8'h28));
    end
    run_table(0, "back_to_back");

    // Reset in D_PW aborts without done; reset also dominates start.
    add(1'b1, 1'b0, 8'h02, 8'h10, exp_out(1, 2, 4, 2, 8'h02, 8'h10));
    for (int c = 2; c <= 12; c++) add(1'b0, 1'b0, 8'h02, 8'h10, exp_out(c, 2, 4, 2, 8'h02, 8'h10));
    add(1'b0, 1'b1, 8'h02, 8'h10, IDLE_OUT);
    add(1'b1, 1'b1, 8'h02, 8'h10, IDLE_OUT);
    for (int r = 0; r < 3; r++) add(1'b0, 1'b0, 8'h02, 8'h10, IDLE_OUT);
    run_table(0, "reset_abort");

    add(1'b1, 1'b0, 8'h3C, 8'hC3, exp_out(1, 2, 4, 2, 8'h3C, 8'hC3));
    for (int c = 2; c <= 19; c++) add(1'b0, 1'b0, 8'h3C, 8'hC3, exp_out(c, 2, 4, 2, 8'h3C, 8'hC3));
    run_table(0, "after_reset");

    // Minimum timing instance.
    add(1'b1, 1'b0, 8'h55, 8'hAA, exp_out(1, 1, 1, 1, 8'h55, 8'hAA));
    for (int c = 2; c <= 9; c++) add(1'b0, 1'b0, 8'h55, 8'hAA, exp_out(c, 1, 1, 1, 8'h55, 8'hAA));
    run_table(1, "min_timing");

    // Hand-written: measure busy length, strobe cycles and done cycle on the 1/1/1 instance.
    busyc = 0; donec = 0; wrmask = 0;
    addr = 8'h11; data_in = 8'h22; start1 = 1'b1;
    @(posedge clk);
    #1;
    start1 = 1'b0;
    for (int c = 1; c <= 20; c++) begin
      if (busy1) busyc++;
      if (!wr_n1) wrmask = wrmask | (1 << c);
      if (done1 && donec == 0) donec = c;
      @(posedge clk);
      #1;
    end
    check_int("min_busy_cycles", busyc, 6);
    check_int("min_wr_low_mask", wrmask, 32'h24);
    check_int("min_done_cycle", donec, 7);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end

endmodule
